red_pitaya_acq_ch: RTL

Single-channel acquisition engine; the receive-side counterpart of the ASG channel. Takes ADC samples, decimates them and writes them continuously into a circular buffer once armed. After a trigger it captures a programmable number of post-trigger samples, then freezes so software can read the buffer back. Sits between the ADC input pipeline and the system-bus register block, one instance per ADC channel.

---
 rtl/red_pitaya_acq_ch.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_acq_ch.sv
// Single-channel acquisition: decimates ADC samples into a circular buffer and freezes after
// a programmable post-trigger count. Define ACQ_AVG_EN to average each decimation window.
module red_pitaya_acq_ch #(
    parameter int RSZ     = 14,
    parameter int DEB_CNT = 62500
) (
    input  logic            adc_clk_i,
    input  logic            adc_rstn_i,
    input  logic [13:0]     adc_dat_i,
    input  logic            trig_sw_i,
    input  logic            trig_ext_i,
    input  logic [2:0]      trig_src_i,
    output logic            trig_o,
    input  logic            set_arm_i,
    input  logic            set_rst_i,
    input  logic [16:0]     set_dec_i,
    input  logic [13:0]     set_thr_i,
    input  logic [13:0]     set_hyst_i,
    input  logic [31:0]     set_dly_i,
    input  logic [RSZ-1:0]  buf_addr_i,
    output logic [13:0]     buf_rdata_o,
    output logic [RSZ-1:0]  sts_wp_o,
    output logic [RSZ-1:0]  sts_trig_wp_o,
    output logic            sts_armed_o,
    output logic            sts_done_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIG = 2'd2, DONE = 2'd3} state_t;
    localparam int DEB_W = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT + 1);

    state_t             state_r, state_nxt_s;
    logic [16:0]        dec_cnt_r, dec_last_s;
    logic               ds_stb_s;
    logic [13:0]        ds_s;
    logic [RSZ-1:0]     wp_r;
    logic [31:0]        dly_cnt_r;
    logic               rdy_p_r, rdy_n_r;
    logic signed [15:0] ds16_s, thr16_s, hyst16_s, thr_lo_s, thr_hi_s;
    logic               lvl_rise_s, lvl_fall_s;
    logic [2:0]         ext_sync_r;
    logic               ext_re_s, ext_fe_s, ext_rise_r, ext_fall_r;
    logic [DEB_W-1:0]   deb_p_r, deb_n_r;
    logic               trig_evt_s, trig_acc_s, we_s;
    logic [13:0]        mem [0:(1<<RSZ)-1];

    always_comb begin
        if (set_dec_i == 17'd0) begin
            dec_last_s = 17'd0;
        end else begin
            dec_last_s = set_dec_i - 17'd1;
        end
        ds_stb_s = (dec_cnt_r >= dec_last_s);
    end

    // Free-running decimation counter; >= keeps it sane when the factor shrinks mid-count.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            dec_cnt_r <= 17'd0;
        end else if (ds_stb_s) begin
            dec_cnt_r <= 17'd0;
        end else begin
            dec_cnt_r <= dec_cnt_r + 17'd1;
        end
    end

`ifdef ACQ_AVG_EN
    logic signed [30:0] acc_r, acc_sum_s;
    logic [4:0]         shift_s;

    always_comb begin
        acc_sum_s = acc_r + {{17{adc_dat_i[13]}}, adc_dat_i};
        case (set_dec_i)
            17'd8:     shift_s = 5'd3;
            17'd64:    shift_s = 5'd6;
            17'd1024:  shift_s = 5'd10;
            17'd8192:  shift_s = 5'd13;
            17'd65536: shift_s = 5'd16;
            default:   shift_s = 5'd0;
        endcase
        ds_s = 14'(acc_sum_s >>> shift_s);
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            acc_r <= 31'sd0;
        end else if (ds_stb_s) begin
            acc_r <= 31'sd0;
        end else begin
            acc_r <= acc_sum_s;
        end
    end
`else
    assign ds_s = adc_dat_i;
`endif

    // Level comparisons widened to 16 bits so thr +/- hyst can never wrap.
    always_comb begin
        ds16_s     = {{2{ds_s[13]}}, ds_s};
        thr16_s    = {{2{set_thr_i[13]}}, set_thr_i};
        hyst16_s   = {2'b00, set_hyst_i};
        thr_lo_s   = thr16_s - hyst16_s;
        thr_hi_s   = thr16_s + hyst16_s;
        lvl_rise_s = ds_stb_s && rdy_p_r && (ds16_s >= thr16_s);
        lvl_fall_s = ds_stb_s && rdy_n_r && (ds16_s <= thr16_s);
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            rdy_p_r <= 1'b0;
            rdy_n_r <= 1'b0;
        end else if (set_rst_i) begin
            rdy_p_r <= 1'b0;
            rdy_n_r <= 1'b0;
        end else if ((state_r == ARMED) && ds_stb_s) begin
            if (lvl_rise_s) begin
                rdy_p_r <= 1'b0;
            end else if (ds16_s <= thr_lo_s) begin
                rdy_p_r <= 1'b1;
            end
            if (lvl_fall_s) begin
                rdy_n_r <= 1'b0;
            end else if (ds16_s >= thr_hi_s) begin
                rdy_n_r <= 1'b1;
            end
        end
    end

    assign ext_re_s = ext_sync_r[1] & ~ext_sync_r[2];
    assign ext_fe_s = ~ext_sync_r[1] & ext_sync_r[2];

    // External trigger: synchronizer, then per-polarity lockout after each accepted edge.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            ext_sync_r <= 3'b000;
            deb_p_r    <= '0;
            deb_n_r    <= '0;
            ext_rise_r <= 1'b0;
            ext_fall_r <= 1'b0;
        end else begin
            ext_sync_r <= {ext_sync_r[1:0], trig_ext_i};
            ext_rise_r <= ext_re_s && (deb_p_r == '0);
            ext_fall_r <= ext_fe_s && (deb_n_r == '0);
            if (ext_re_s && (deb_p_r == '0)) begin
                deb_p_r <= DEB_W'(DEB_CNT);
            end else if (deb_p_r != '0) begin
                deb_p_r <= deb_p_r - DEB_W'(1);
            end
            if (ext_fe_s && (deb_n_r == '0)) begin
                deb_n_r <= DEB_W'(DEB_CNT);
            end else if (deb_n_r != '0) begin
                deb_n_r <= deb_n_r - DEB_W'(1);
            end
        end
    end

    always_comb begin
        case (trig_src_i)
            3'd1:    trig_evt_s = trig_sw_i;
            3'd2:    trig_evt_s = lvl_rise_s;
            3'd3:    trig_evt_s = lvl_fall_s;
            3'd4:    trig_evt_s = ext_rise_r;
            3'd5:    trig_evt_s = ext_fall_r;
            default: trig_evt_s = 1'b0;
        endcase
    end

    // The trigger clock itself is not written, so sts_trig_wp_o addresses the first
    // post-trigger sample.
    always_comb begin
        state_nxt_s = state_r;
        we_s        = 1'b0;
        trig_acc_s  = 1'b0;
        if (set_rst_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (set_arm_i) begin
                        state_nxt_s = ARMED;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARMED: begin
                    if (trig_evt_s && !set_arm_i) begin
                        trig_acc_s  = 1'b1;
                        state_nxt_s = TRIG;
                    end else begin
                        we_s = ds_stb_s;
                    end
                end
                TRIG: begin
                    if (dly_cnt_r == 32'd0) begin
                        state_nxt_s = DONE;
                    end else begin
                        we_s = ds_stb_s;
                    end
                end
                DONE: begin
                    if (set_arm_i) begin
                        state_nxt_s = ARMED;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_r       <= IDLE;
            wp_r          <= '0;
            dly_cnt_r     <= 32'd0;
            sts_trig_wp_o <= '0;
            trig_o        <= 1'b0;
            sts_armed_o   <= 1'b0;
            sts_done_o    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            trig_o      <= trig_acc_s;
            sts_armed_o <= (state_nxt_s == ARMED) || (state_nxt_s == TRIG);
            sts_done_o  <= (state_nxt_s == DONE);
            if (trig_acc_s) begin
                sts_trig_wp_o <= wp_r;
            end
            if (set_rst_i) begin
                wp_r      <= '0;
                dly_cnt_r <= 32'd0;
            end else begin
                if (we_s) begin
                    wp_r <= wp_r + RSZ'(1);
                end
                if (trig_acc_s) begin
                    dly_cnt_r <= set_dly_i;
                end else if (we_s && (state_r == TRIG)) begin
                    dly_cnt_r <= dly_cnt_r - 32'd1;
                end
            end
        end
    end

    assign sts_wp_o = wp_r;

    always_ff @(posedge adc_clk_i) begin
        if (we_s) begin
            mem[wp_r] <= ds_s;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            buf_rdata_o <= 14'd0;
        end else begin
            buf_rdata_o <= mem[buf_addr_i];
        end
    end

endmodule
